// File: rtl/cf_shift_reg_n.sv
// Byte-rotation register for the ReC/ReF path: load one of two words, rotate it by a
// programmable byte count for a programmable number of steps, present the result.
// Optional feature macro: CF_ROT_DIR_EN (adds rot_left input for left rotation).

module cf_rot_lane #(
  parameter int IDX_W = 3
) (
  input  logic [2**IDX_W-1:0][7:0] win,
  input  logic [IDX_W-1:0]         sel,
  output logic [7:0]               lane_q
);
  assign lane_q = win[sel];
endmodule

module cf_shift_reg_n #(
  parameter  int DATA_W      = 128,
  parameter  int MAX_SHIFT_B = 4,
  parameter  int CNT_W       = 8,
  localparam int SH_W        = $clog2(MAX_SHIFT_B + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic [DATA_W-1:0] src_c,
  input  logic [DATA_W-1:0] src_f,
  input  logic [SH_W-1:0]   shamt,
  input  logic [CNT_W-1:0]  nsteps,
`ifdef CF_ROT_DIR_EN
  input  logic              rot_left,
`endif
  output logic [DATA_W-1:0] q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int NUM_LANES = DATA_W / 8;
`ifdef CF_ROT_DIR_EN
  localparam int IDX_W = SH_W + 1;
  localparam int K_OFF = 2**SH_W - 1;
`else
  localparam int IDX_W = SH_W;
  localparam int K_OFF = 0;
`endif
  localparam int WIN = 2**IDX_W;
  localparam logic [SH_W-1:0] MAX_SH = SH_W'(MAX_SHIFT_B);

  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("cf_shift_reg_n: DATA_W must be a multiple of 8");
  end
  if (MAX_SHIFT_B < 1 || MAX_SHIFT_B > NUM_LANES - 1) begin : g_bad_shift
    $error("cf_shift_reg_n: MAX_SHIFT_B out of range");
  end

  typedef enum logic [1:0] {IDLE, ROT, PRESENT} state_t;

  state_t                        state, state_nxt;
  logic [NUM_LANES-1:0][7:0]     q_r, rot_q;
  logic [NUM_LANES-1:0][WIN-1:0][7:0] win;
  logic [CNT_W-1:0]              cnt;
  logic [SH_W-1:0]               shift_r;
  logic [IDX_W-1:0]              sel;
  logic                          accept, take, done_r, err_r;
`ifdef CF_ROT_DIR_EN
  logic                          dir_r;
`endif

  assign take      = (state == PRESENT) & out_ready;
  assign in_ready  = (state == IDLE) | take;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == PRESENT);
  assign busy      = (state != IDLE);
  assign done      = done_r;
  assign err       = err_r;
  assign q         = q_r;

  // Each lane sees a byte window of q centred so that sel=K_OFF is the identity.
`ifdef CF_ROT_DIR_EN
  assign sel = dir_r ? IDX_W'(K_OFF) - IDX_W'(shift_r) : IDX_W'(K_OFF) + IDX_W'(shift_r);
`else
  assign sel = shift_r;
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    for (genvar j = 0; j < WIN; j++) begin : g_win
      assign win[i][j] = q_r[(i + j + 2*NUM_LANES - K_OFF) % NUM_LANES];
    end
    cf_rot_lane #(.IDX_W(IDX_W)) u_lane (
      .win    (win[i]),
      .sel    (sel),
      .lane_q (rot_q[i])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (nsteps != '0) ? ROT : PRESENT;
      ROT:     if (cnt == CNT_W'(1)) state_nxt = PRESENT;
      PRESENT: begin
        if (accept)         state_nxt = (nsteps != '0) ? ROT : PRESENT;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      q_r     <= '0;
      cnt     <= '0;
      shift_r <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
`ifdef CF_ROT_DIR_EN
      dir_r   <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      done_r <= take;
      err_r  <= accept & (shamt > MAX_SH);
      if (accept) begin
        q_r     <= in_sel ? src_f : src_c;
        cnt     <= nsteps;
        shift_r <= (shamt > MAX_SH) ? MAX_SH : shamt;
`ifdef CF_ROT_DIR_EN
        dir_r   <= rot_left;
`endif
      end else if (state == ROT) begin
        q_r <= rot_q;
        cnt <= cnt - CNT_W'(1);
      end
    end
  end
endmodule
